// File: rtl/dekatron_digit_loader.sv
// Dekatron digit loader: steps each decade tube, least-significant digit
// first, until its sensed one-hot cathode position matches the latched BCD
// target. Pulse and gap lengths are parameters. A single-cycle Done strobe
// reports the result, and Error/ErrDigit are valid alongside it.
// Optional feature macro: DEKATRON_BIDIR_EN adds the StepRev output and
// shortest-direction stepping.
module dekatron_digit_loader #(
    parameter int DIGITS       = 3,
    parameter int PULSE_CYCLES = 4,
    parameter int GAP_CYCLES   = 4
) (
    input  logic                                           Clk,
    input  logic                                           Rst,
    input  logic                                           Request,
    input  logic [4*DIGITS-1:0]                            Target,
    input  logic [10*DIGITS-1:0]                           Position,
    output logic [DIGITS-1:0]                              Step,
`ifdef DEKATRON_BIDIR_EN
    output logic [DIGITS-1:0]                              StepRev,
`endif
    output logic                                           Busy,
    output logic                                           Done,
    output logic                                           Error,
    output logic [((DIGITS > 1) ? $clog2(DIGITS) : 1)-1:0] ErrDigit
);

    localparam int IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int TMAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [TW-1:0] T_PULSE    = TW'(PULSE_CYCLES - 1);
    localparam logic [TW-1:0] T_GAP      = TW'(GAP_CYCLES - 1);
    localparam logic [IW-1:0] LAST_DIGIT = IW'(DIGITS - 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_VALIDATE = 3'd1;
    localparam logic [2:0] S_CHECK    = 3'd2;
    localparam logic [2:0] S_PULSE    = 3'd3;
    localparam logic [2:0] S_GAP      = 3'd4;
    localparam logic [2:0] S_DONE     = 3'd5;

    logic [2:0]          r_state;
    logic [4*DIGITS-1:0] r_target;
    logic [IW-1:0]       r_digit;
    logic [3:0]          r_step_cnt;
    logic [TW-1:0]       r_timer;
    logic [DIGITS-1:0]   r_step;
    logic                r_busy;
    logic                r_done;
    logic                r_error;
    logic [IW-1:0]       r_err_digit;

    logic [3:0]          w_tgt_digit;
    logic [9:0]          w_pos;
    logic [DIGITS-1:0]   w_sel;
    logic                w_bad_any;
    logic [IW-1:0]       w_bad_idx;
    logic                w_pos_ok;
    logic                w_match;

    // Population count of a cathode sense vector.
    function automatic logic [3:0] ones_count(input logic [9:0] v);
        logic [3:0] cnt;
        cnt = 4'd0;
        for (int i = 0; i < 10; i++) begin
            cnt = cnt + {3'd0, v[i]};
        end
        return cnt;
    endfunction

`ifdef DEKATRON_BIDIR_EN
    logic [DIGITS-1:0] r_step_rev;
    logic [3:0]        w_pos_idx;
    logic [3:0]        w_fwd;
    logic [3:0]        w_rev;
    logic              w_use_rev;

    // Cathode index of a one-hot sense vector.
    function automatic logic [3:0] onehot_index(input logic [9:0] oh);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 0; i < 10; i++) begin
            idx = oh[i] ? 4'(i) : idx;
        end
        return idx;
    endfunction

    // (a - b) mod 10 for decimal digits.
    function automatic logic [3:0] mod10_sub(input logic [3:0] a, input logic [3:0] b);
        logic [4:0] s;
        s = {1'b0, a} + 5'd10 - {1'b0, b};
        if (s >= 5'd10) begin
            s = s - 5'd10;
        end else begin
            s = s;
        end
        return s[3:0];
    endfunction

    assign w_pos_idx = onehot_index(w_pos);
    assign w_fwd     = mod10_sub(w_tgt_digit, w_pos_idx);
    assign w_rev     = mod10_sub(w_pos_idx, w_tgt_digit);
    assign w_use_rev = (w_rev < w_fwd);
    assign StepRev   = r_step_rev;
`endif

    assign Step     = r_step;
    assign Busy     = r_busy;
    assign Done     = r_done;
    assign Error    = r_error;
    assign ErrDigit = r_err_digit;

    assign w_pos_ok = (ones_count(w_pos) == 4'd1);
    assign w_match  = (w_pos == (10'd1 << w_tgt_digit));

    // Select the active digit's latched target, sensed position and step lane.
    always_comb begin
        w_tgt_digit = 4'd0;
        w_pos       = 10'd0;
        w_sel       = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_digit == IW'(i)) begin
                w_tgt_digit = r_target[4*i +: 4];
                w_pos       = Position[10*i +: 10];
                w_sel[i]    = 1'b1;
            end else begin
                w_sel[i]    = 1'b0;
            end
        end
    end

    // Find the lowest latched digit that is not valid BCD.
    always_comb begin
        w_bad_any = 1'b0;
        w_bad_idx = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (r_target[4*i +: 4] > 4'd9) begin
                w_bad_any = 1'b1;
                w_bad_idx = IW'(i);
            end else begin
                w_bad_idx = w_bad_idx;
            end
        end
    end

    // Load sequencer: validate, then check/pulse/gap each digit in turn.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state     <= S_IDLE;
            r_target    <= '0;
            r_digit     <= '0;
            r_step_cnt  <= 4'd0;
            r_timer     <= '0;
            r_step      <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_err_digit <= '0;
`ifdef DEKATRON_BIDIR_EN
            r_step_rev  <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (Request) begin
                        r_target   <= Target;
                        r_digit    <= '0;
                        r_step_cnt <= 4'd0;
                        r_busy     <= 1'b1;
                        r_state    <= S_VALIDATE;
                    end else begin
                        r_state    <= S_IDLE;
                    end
                end
                S_VALIDATE: begin
                    if (w_bad_any) begin
                        r_state     <= S_DONE;
                        r_done      <= 1'b1;
                        r_busy      <= 1'b0;
                        r_error     <= 1'b1;
                        r_err_digit <= w_bad_idx;
                    end else begin
                        r_state     <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (!w_pos_ok || (!w_match && (r_step_cnt == 4'd9))) begin
                        // Broken sense line or stuck tube.
                        r_state     <= S_DONE;
                        r_done      <= 1'b1;
                        r_busy      <= 1'b0;
                        r_error     <= 1'b1;
                        r_err_digit <= r_digit;
                    end else if (w_match) begin
                        if (r_digit == LAST_DIGIT) begin
                            r_state     <= S_DONE;
                            r_done      <= 1'b1;
                            r_busy      <= 1'b0;
                            r_error     <= 1'b0;
                            r_err_digit <= '0;
                        end else begin
                            r_digit    <= r_digit + IW'(1);
                            r_step_cnt <= 4'd0;
                        end
                    end else begin
                        r_state    <= S_PULSE;
                        r_step_cnt <= r_step_cnt + 4'd1;
                        r_timer    <= T_PULSE;
`ifdef DEKATRON_BIDIR_EN
                        if (w_use_rev) begin
                            r_step_rev <= w_sel;
                        end else begin
                            r_step     <= w_sel;
                        end
`else
                        r_step     <= w_sel;
`endif
                    end
                end
                S_PULSE: begin
                    if (r_timer == '0) begin
                        r_step     <= '0;
`ifdef DEKATRON_BIDIR_EN
                        r_step_rev <= '0;
`endif
                        r_timer    <= T_GAP;
                        r_state    <= S_GAP;
                    end else begin
                        r_timer    <= r_timer - TW'(1);
                    end
                end
                S_GAP: begin
                    if (r_timer == '0) begin
                        r_state <= S_CHECK;
                    end else begin
                        r_timer <= r_timer - TW'(1);
                    end
                end
                S_DONE: begin
                    r_done      <= 1'b0;
                    r_error     <= 1'b0;
                    r_err_digit <= '0;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_step  <= '0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/dekatron_digit_loader.md
Name: dekatron_digit_loader

Overview:
Sequencer that loads a multi-digit dekatron register to a requested BCD value by issuing step pulses to each tube until its sensed one-hot position matches the decoded target. Sits between the control unit, which supplies 8-4-2-1 digits, and the dekatron tube drivers and cathode sense lines. Digits are processed one at a time, least-significant first, with programmable pulse and gap timing. Completion and error are reported by a single-cycle done strobe.

Parameters:
DIGITS, 3, number of decade tubes handled
PULSE_CYCLES, 4, Clk cycles each step pulse is held high (>=1)
GAP_CYCLES, 4, Clk cycles between pulse end and re-sampling Position (>=1)

Ports:
Clk  input  1  system clock
Rst  input  1  synchronous reset, active-high
Request  input  1  start load; sampled only in IDLE
Target  input  4*DIGITS  BCD target; digit d at [4d+3:4d]
Position  input  10*DIGITS  sensed one-hot cathode positions; digit d at [10d+9:10d]
Step  output  DIGITS  forward step pulse per tube
Busy  output  1  high from the cycle after accepted Request until Done
Done  output  1  one-cycle completion strobe
Error  output  1  valid only with Done: load failed
ErrDigit  output  $clog2(DIGITS)  with Error: index of the failing digit

Behaviour:
- Interface: one clock (Clk); reset Rst is synchronous and active-high.
- Reset: Step=0, Busy=0, Done=0, Error=0, ErrDigit=0, FSM=IDLE, digit index=0, step count=0. Rst mid-load drops Step in the same clock edge. No partial completion is reported.
- IDLE: when Request=1, latch Target into an internal register, set digit=0, and go to VALIDATE. Busy rises on the next cycle. Request while Busy is ignored and does not queue.
- VALIDATE (1 cycle): any latched digit >9 -> DONE with Error=1 and ErrDigit=lowest offending index. No Step is issued. Otherwise -> CHECK.
- CHECK (1 cycle): decode the latched digit to one-hot and compare it with Position[d].
  - Position[d] not exactly one-hot (zero or multiple bits) -> DONE, Error=1, ErrDigit=d.
  - Position matches: if d=DIGITS-1 -> DONE (Error=0). Otherwise d++, step count=0, stay in CHECK.
  - Mismatch: if step count=9 -> DONE, Error=1, ErrDigit=d (stuck tube). Otherwise -> PULSE.
- PULSE: Step[d]=1 for exactly PULSE_CYCLES cycles. Only one Step bit is ever high. Step count increments on entry. Then -> GAP.
- GAP: Step=0 for GAP_CYCLES cycles. Position is ignored during this state. Then -> CHECK.
- DONE (1 cycle): Done=1, Busy=0, Error/ErrDigit driven, then -> IDLE. Error and ErrDigit return to 0 in IDLE.
- Latency for a digit already matching: 1 CHECK cycle.
- Each forward step costs PULSE_CYCLES+GAP_CYCLES+1 cycles.
- Ring wrap-around: Position 9 stepped goes to 0. Forward from p to t takes (t-p) mod 10 steps.
- Target changes while Busy have no effect, because the target is latched.

Optional Feature:
DEKATRON_BIDIR_EN:
- Defined: adds output port StepRev [DIGITS-1:0] (reverse pulse, same timing as Step).
- In CHECK on mismatch, compute fwd=(t-p) mod 10 and rev=(p-t) mod 10. Pulse StepRev[d] if rev<fwd, otherwise pulse Step[d]; a tie uses forward.
- The direction is re-evaluated at every CHECK. At most one of Step/StepRev is high.
- Undefined: StepRev does not exist and only forward stepping is used. Stuck limit stays 9 steps in both builds.

Test Plan:
- Reset mid-PULSE (Step[0]=1) -> next cycle Step=0, Busy=0, Done=0; following Request starts a fresh load.
- DIGITS=3, Position=all at 0, Target=0x000, Request -> Done after VALIDATE+3 CHECK cycles, Error=0, no Step pulses.
- Position digit0=3 (model advances on each Step falling edge), Target=0x007 -> exactly 4 Step[0] pulses of 4 cycles each, 4-cycle gaps, then Done, Error=0.
- Wrap-around: digit1 at 8, target 2 -> 4 Step[1] pulses (8->9->0->1->2); with DEKATRON_BIDIR_EN -> 4 Step[1] pulses, since fwd=4, rev=6.
- Target=0x0A5 -> Done 2 cycles after Request accept with Error=1, ErrDigit=1, no Step ever high.
- Position model ignoring Step[2] stuck at 4, target 5 -> 9 pulses, then Done with Error=1, ErrDigit=2. Position digit0=0 (no bits set) -> Error=1, ErrDigit=0.
